// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read SRAM between instruction fetch and
// load/store ports; every granted transfer is acknowledged exactly one cycle later.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0] state, state_next;
    logic       last, last_next;    // 0 = inst, 1 = data was granted most recently
    logic       elig_i, elig_d;
    logic       grant_i, grant_d;

    // The port owning the current BUSY state still holds req in its ack cycle; ignore it.
    always_comb begin
        elig_i  = inst_req && (state != BUSY_I) && !rst;
        elig_d  = data_req && (state != BUSY_D) && !rst;
        grant_i = elig_i && (!elig_d || last);
        grant_d = elig_d && (!elig_i || !last);
    end

    always_comb begin
        sram_en    = grant_i || grant_d;
        sram_wen   = 4'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_d) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (grant_i) begin
            sram_addr  = inst_addr;
        end
    end

    always_comb begin
        inst_ack   = (state == BUSY_I) && !rst;
        data_ack   = (state == BUSY_D) && !rst;
        inst_rdata = sram_rdata;
        data_rdata = sram_rdata;
    end

    always_comb begin
        state_next = IDLE;
        last_next  = last;
        if (grant_d) begin
            state_next = BUSY_D;
            last_next  = 1'b1;
        end else if (grant_i) begin
            state_next = BUSY_I;
            last_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, reset-mid-transfer sequence, then random
// traffic checked against a word-array memory model and a per-port wait bound.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ack   (inst_ack),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    function automatic logic [31:0] init_word(int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 | 32'(k);
        if (k == 2) w = 32'h0041_1021;
        return w;
    endfunction

    // SRAM environment: reloads its initial image whenever rst is high.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            sram_rdata <= '0;
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= mem[sram_addr[9:2]];
        end
    end

    a_inst_hold: assert property (@(posedge clk) disable iff (rst)
        $fell(inst_req) |-> $past(inst_ack));
    a_data_hold: assert property (@(posedge clk) disable iff (rst)
        $fell(data_req) |-> $past(data_ack));

    task automatic tally(input bit ok, input string msg);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tally(act === exp, $sformatf("%s: got %h, expected %h", nm, act, exp));
    endtask

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        iack;
        logic        dack;
        logic        en;
        logic [3:0]  swen;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        chk_i;
        logic [31:0] irdata;
        logic        chk_d;
        logic [31:0] drdata;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        rst = r; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
    endtask

    // Random-phase model state
    logic [31:0] ref_mem [256];
    int          cyc;
    bit          i_pend, d_pend, i_late, d_late;
    int          i_issue, d_issue;
    logic [31:0] i_a, d_a, d_wd;
    logic [3:0]  d_w;

    initial begin
        vec_t v;
        //        rst ireq iaddr  dreq dwen daddr  dwdata   iack dack en swen saddr swdata ci irdata cd drdata
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1, 1, 32'h40, 1, 4'h0, 32'h44, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h40, 1, 4'h0, 32'h44, 32'h0, 0, 0, 1, 4'h0, 32'h44, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h40, 1, 4'h0, 32'h44, 32'h0, 0, 1, 1, 4'h0, 32'h40, 32'h0, 0, 32'h0, 1, 32'hA5A50011});
        vecs.push_back('{0, 1, 32'h40, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A50010, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0});
        // lone fetch
        vecs.push_back('{0, 1, 32'h8, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h8, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h8, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h00411021, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0});
        // store then load
        vecs.push_back('{0, 0, 32'h0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0, 0, 1, 4'h0, 32'h10, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF});
        // contention: last=data, so inst wins first, then strict alternation
        vecs.push_back('{0, 1, 32'h20, 1, 4'h0, 32'h24, 32'h0, 0, 0, 1, 4'h0, 32'h20, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h20, 1, 4'h0, 32'h24, 32'h0, 1, 0, 1, 4'h0, 32'h24, 32'h0, 1, 32'hA5A50008, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h28, 1, 4'h0, 32'h24, 32'h0, 0, 1, 1, 4'h0, 32'h28, 32'h0, 0, 32'h0, 1, 32'hA5A50009});
        vecs.push_back('{0, 1, 32'h28, 1, 4'h3, 32'h2C, 32'h12345678, 1, 0, 1, 4'h3, 32'h2C, 32'h12345678, 1, 32'hA5A5000A, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h2C, 1, 4'h3, 32'h2C, 32'h12345678, 0, 1, 1, 4'h0, 32'h2C, 32'h0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h2C, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A55678, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0});

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.rst, v.ireq, v.iaddr, v.dreq, v.dwen, v.daddr, v.dwdata);
            @(negedge clk);
            chk($sformatf("row%0d inst_ack", i), 32'(inst_ack), 32'(v.iack));
            chk($sformatf("row%0d data_ack", i), 32'(data_ack), 32'(v.dack));
            chk($sformatf("row%0d sram_en", i), 32'(sram_en), 32'(v.en));
            chk($sformatf("row%0d sram_wen", i), 32'(sram_wen), 32'(v.swen));
            chk($sformatf("row%0d sram_addr", i), sram_addr, v.saddr);
            chk($sformatf("row%0d sram_wdata", i), sram_wdata, v.swdata);
            if (v.chk_i) chk($sformatf("row%0d inst_rdata", i), inst_rdata, v.irdata);
            if (v.chk_d) chk($sformatf("row%0d data_rdata", i), data_rdata, v.drdata);
            @(posedge clk); #1;
        end

        // Reset in the BUSY_D cycle: no ack, back to IDLE, re-issued load completes.
        drive(0, 0, 32'h0, 1, 4'h0, 32'h30, 32'h0);
        @(negedge clk); chk("rmt grant", 32'(sram_en), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("rmt ack in rst", 32'(data_ack), 32'd0);
        chk("rmt en in rst", 32'(sram_en), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("rmt reissue en", 32'(sram_en), 32'd1);
        chk("rmt reissue no ack", 32'(data_ack), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("rmt ack", 32'(data_ack), 32'd1);
        chk("rmt rdata", data_rdata, 32'hA5A5000C);
        @(posedge clk); #1; data_req = 1'b0;
        @(negedge clk); chk("rmt no dup ack", 32'(data_ack), 32'd0);

        // Random traffic against a word-array model; acks arrive in grant order.
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        cyc = 0; i_pend = 0; d_pend = 0; i_late = 0; d_late = 0;
        for (int c = 0; c < 10000; c++) begin
            bit i_done, d_done;
            @(posedge clk); cyc++; #1;
            if (!i_pend && $urandom_range(0, 3) != 0) begin
                i_pend = 1; i_late = 0; i_issue = cyc;
                i_a = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1; d_late = 0; d_issue = cyc;
                d_a = 32'($urandom_range(0, 63)) << 2;
                d_w = ($urandom_range(0, 1) != 0) ? 4'(($urandom)) : 4'h0;
                d_wd = $urandom;
            end
            drive(0, i_pend, i_pend ? i_a : 32'h0, d_pend, d_pend ? d_w : 4'h0,
                  d_pend ? d_a : 32'h0, d_pend ? d_wd : 32'h0);
            @(negedge clk);
            i_done = 0; d_done = 0;
            tally(!(inst_ack && data_ack), $sformatf("rnd dual ack at cycle %0d", cyc));
            if (inst_ack) begin
                tally(i_pend, $sformatf("rnd inst spurious ack at cycle %0d", cyc));
                if (i_pend) begin
                    tally(cyc - i_issue >= 1 && cyc - i_issue <= 2,
                          $sformatf("rnd inst wait: got %0d cycles, required 1..2", cyc - i_issue));
                    chk($sformatf("rnd inst_rdata @%h", i_a), inst_rdata, ref_mem[i_a[9:2]]);
                    i_done = 1;
                end
            end else if (i_pend && !i_late && cyc - i_issue >= 2) begin
                tally(0, $sformatf("rnd inst ack missing: waited %0d cycles, required <=2", cyc - i_issue));
                i_late = 1;
            end
            if (data_ack) begin
                tally(d_pend, $sformatf("rnd data spurious ack at cycle %0d", cyc));
                if (d_pend) begin
                    tally(cyc - d_issue >= 1 && cyc - d_issue <= 2,
                          $sformatf("rnd data wait: got %0d cycles, required 1..2", cyc - d_issue));
                    if (d_w == 4'h0)
                        chk($sformatf("rnd data_rdata @%h", d_a), data_rdata, ref_mem[d_a[9:2]]);
                    else
                        for (int b = 0; b < 4; b++)
                            if (d_w[b]) ref_mem[d_a[9:2]][8*b +: 8] = d_wd[8*b +: 8];
                    d_done = 1;
                end
            end else if (d_pend && !d_late && cyc - d_issue >= 2) begin
                tally(0, $sformatf("rnd data ack missing: waited %0d cycles, required <=2", cyc - d_issue));
                d_late = 1;
            end
            if (i_done) i_pend = 0;
            if (d_done) d_pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
